rv_mul_div_unit: RTL

RV_MUL_DIV_UNIT -- requirements
Module: rv_mul_div_unit

---
 rtl/rv_mul_div_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rv_mul_div_unit.sv
// RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Latency: XLEN+1 cycles from accept to resp_valid; 1 cycle for early-out divide corner cases.
// Backpressure: single operation in flight; req_ready only in IDLE, result held in DONE until resp_ready.
module rv_mul_div_unit #(
    parameter int XLEN      = 32,
    parameter int ID_WIDTH  = 5,
    parameter int EARLY_OUT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_funct3,
    input  logic [XLEN-1:0]     req_rs1,
    input  logic [XLEN-1:0]     req_rs2,
    input  logic [ID_WIDTH-1:0] req_id,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_result,
    output logic [ID_WIDTH-1:0] resp_id
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST     = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic [2:0]          funct3_q;
    logic [ID_WIDTH-1:0] id_q;
    logic                neg_q;
    logic [XLEN:0]       acc_hi;
    logic [XLEN-1:0]     acc_lo;
    logic [XLEN-1:0]     opnd;

    logic                req_s1, req_s2, sign1, sign2, rs2_zero, ovf, early, req_neg;
    logic [XLEN-1:0]     mag1, mag2, early_res;

    always_comb begin
        req_s1    = (req_funct3 == 3'd1) || (req_funct3 == 3'd2) ||
                    (req_funct3 == 3'd4) || (req_funct3 == 3'd6);
        req_s2    = (req_funct3 == 3'd1) || (req_funct3 == 3'd4) || (req_funct3 == 3'd6);
        sign1     = req_s1 & req_rs1[XLEN-1];
        sign2     = req_s2 & req_rs2[XLEN-1];
        mag1      = sign1 ? -req_rs1 : req_rs1;
        mag2      = sign2 ? -req_rs2 : req_rs2;
        rs2_zero  = (req_rs2 == '0);
        ovf       = req_funct3[2] & ~req_funct3[0] & (req_rs1 == MOST_NEG) & (&req_rs2);
        early     = (EARLY_OUT != 0) && req_funct3[2] && (rs2_zero || ovf);
        if (rs2_zero)
            early_res = req_funct3[1] ? req_rs1 : '1;
        else
            early_res = req_funct3[1] ? '0 : MOST_NEG;
        // A zero divisor must not flip the all-ones quotient, even for signed DIV.
        if (req_funct3[2])
            req_neg = req_funct3[1] ? sign1 : ((sign1 ^ sign2) & ~rs2_zero);
        else
            req_neg = sign1 ^ sign2;
    end

    logic [XLEN:0]       mul_sum, div_shift, div_diff, nxt_hi;
    logic [XLEN-1:0]     nxt_lo, div_raw, final_res;
    logic [2*XLEN-1:0]   prod, prod_s;

    always_comb begin
        mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi[XLEN-1:0], acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (funct3_q[2]) begin
            nxt_hi = div_diff[XLEN] ? div_shift : div_diff;
            nxt_lo = {acc_lo[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            nxt_hi = {1'b0, mul_sum[XLEN:1]};
            nxt_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
        prod    = {nxt_hi[XLEN-1:0], nxt_lo};
        prod_s  = neg_q ? -prod : prod;
        div_raw = funct3_q[1] ? nxt_hi[XLEN-1:0] : nxt_lo;
        if (funct3_q[2])
            final_res = neg_q ? -div_raw : div_raw;
        else if (funct3_q[1:0] == 2'd0)
            final_res = prod_s[XLEN-1:0];
        else
            final_res = prod_s[2*XLEN-1:XLEN];
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            funct3_q    <= '0;
            id_q        <= '0;
            neg_q       <= 1'b0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opnd        <= '0;
            resp_result <= '0;
            resp_id     <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        funct3_q <= req_funct3;
                        id_q     <= req_id;
                        neg_q    <= req_neg;
                        cnt      <= '0;
                        acc_hi   <= '0;
                        acc_lo   <= req_funct3[2] ? mag1 : mag2;
                        opnd     <= req_funct3[2] ? mag2 : mag1;
                        if (early) begin
                            state       <= S_DONE;
                            resp_result <= early_res;
                            resp_id     <= req_id;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state       <= S_DONE;
                        resp_result <= final_res;
                        resp_id     <= id_q;
                    end
                end
                S_DONE: begin
                    if (resp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
